// File: rtl/procyon_core_pkg.sv
// Core-wide state encodings.
package procyon_core_pkg;

  typedef enum logic [1:0] {
    PCYN_CCU_RESP_IDLE = 2'd0,
    PCYN_CCU_RESP_BUSY = 2'd1,
    PCYN_CCU_RESP_DONE = 2'd2
  } pcyn_ccu_resp_state_t;

endpackage

// File: rtl/procyon_lib_pkg.sv
// Shared library types and helpers for CCU requesters and responders.
package procyon_lib_pkg;

  typedef enum logic [2:0] {
    PCYN_CCU_LEN_4B   = 3'd0,
    PCYN_CCU_LEN_8B   = 3'd1,
    PCYN_CCU_LEN_16B  = 3'd2,
    PCYN_CCU_LEN_32B  = 3'd3,
    PCYN_CCU_LEN_64B  = 3'd4,
    PCYN_CCU_LEN_128B = 3'd5
  } pcyn_ccu_len_t;

  // Unknown encodings fall back to the smallest transfer.
  function automatic logic [7:0] pcyn_ccu_len_to_bytes(input pcyn_ccu_len_t len);
    case (len)
      PCYN_CCU_LEN_4B:   return 8'd4;
      PCYN_CCU_LEN_8B:   return 8'd8;
      PCYN_CCU_LEN_16B:  return 8'd16;
      PCYN_CCU_LEN_32B:  return 8'd32;
      PCYN_CCU_LEN_64B:  return 8'd64;
      PCYN_CCU_LEN_128B: return 8'd128;
      default:           return 8'd4;
    endcase
  endfunction

endpackage

// File: rtl/procyon_ccu_beat_ctrl.sv
// Beat index counter with last-beat flag and beat address generator.
module procyon_ccu_beat_ctrl #(
  parameter int unsigned OPTN_ADDR_WIDTH    = 32,
  parameter int unsigned OPTN_MEM_DATA_SIZE = 4,
  parameter int unsigned CNT_W              = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [OPTN_ADDR_WIDTH-1:0] load_base,
  input  logic [CNT_W-1:0]           load_nbeats,
  input  logic                       advance,
  output logic [CNT_W-1:0]           beat_idx,
  output logic                       last,
  output logic [OPTN_ADDR_WIDTH-1:0] addr
);

  localparam int unsigned MEM_SHIFT = $clog2(OPTN_MEM_DATA_SIZE);

  logic [CNT_W-1:0]           idx_q;
  logic [CNT_W-1:0]           last_idx_q;
  logic [OPTN_ADDR_WIDTH-1:0] base_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      last_idx_q <= '0;
      base_q     <= '0;
    end else if (load) begin
      idx_q      <= '0;
      last_idx_q <= load_nbeats - CNT_W'(1);
      base_q     <= load_base;
    end else if (advance) begin
      idx_q      <= idx_q + CNT_W'(1);
    end
  end

  assign beat_idx = idx_q;
  assign last     = (idx_q == last_idx_q);
  assign addr     = base_q + (OPTN_ADDR_WIDTH'(idx_q) << MEM_SHIFT);

endmodule

// File: rtl/procyon_ccu_mem_responder.sv
// CCU responder: splits one line request into memory-bus beats and assembles read lines.
module procyon_ccu_mem_responder
  import procyon_lib_pkg::*;
  import procyon_core_pkg::*;
#(
  parameter int unsigned OPTN_ADDR_WIDTH    = 32,
  parameter int unsigned OPTN_MAX_LINE_SIZE = 32,
  parameter int unsigned OPTN_MEM_DATA_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_ccu_en,
  input  logic                            i_ccu_we,
  input  pcyn_ccu_len_t                   i_ccu_len,
  input  logic [OPTN_ADDR_WIDTH-1:0]      i_ccu_addr,
  input  logic [OPTN_MAX_LINE_SIZE*8-1:0] i_ccu_data,
  output logic                            o_ccu_done,
  output logic [OPTN_MAX_LINE_SIZE*8-1:0] o_ccu_data,
  output logic                            o_mem_req,
  output logic                            o_mem_we,
  output logic [OPTN_ADDR_WIDTH-1:0]      o_mem_addr,
  output logic [OPTN_MEM_DATA_SIZE*8-1:0] o_mem_wdata,
  input  logic                            i_mem_ack,
  input  logic [OPTN_MEM_DATA_SIZE*8-1:0] i_mem_rdata
);

  localparam int unsigned LINE_W    = OPTN_MAX_LINE_SIZE * 8;
  localparam int unsigned MEM_W     = OPTN_MEM_DATA_SIZE * 8;
  localparam int unsigned MAX_BEATS = OPTN_MAX_LINE_SIZE / OPTN_MEM_DATA_SIZE;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int unsigned MEM_SHIFT = $clog2(OPTN_MEM_DATA_SIZE);

  pcyn_ccu_resp_state_t state_q, state_d;

  logic                       we_q;
  logic [LINE_W-1:0]          line_q;
  logic                       load;
  logic                       advance;
  logic [CNT_W-1:0]           beat_idx;
  logic                       beat_last;

  logic [7:0]                 req_bytes;
  logic [7:0]                 req_span;
  logic [CNT_W-1:0]           req_nbeats;
  logic [OPTN_ADDR_WIDTH-1:0] req_base;

  // Span is the clamped length, widened to at least one beat; it sets both the
  // beat count and the base-address alignment.
  always_comb begin
    req_bytes = pcyn_ccu_len_to_bytes(i_ccu_len);
    if (req_bytes > 8'(OPTN_MAX_LINE_SIZE)) req_bytes = 8'(OPTN_MAX_LINE_SIZE);
    req_span = req_bytes;
    if (req_bytes < 8'(OPTN_MEM_DATA_SIZE)) req_span = 8'(OPTN_MEM_DATA_SIZE);
    req_nbeats = CNT_W'(req_span >> MEM_SHIFT);
    req_base   = i_ccu_addr & ~(OPTN_ADDR_WIDTH'(req_span) - OPTN_ADDR_WIDTH'(1));
  end

  procyon_ccu_beat_ctrl #(
    .OPTN_ADDR_WIDTH    (OPTN_ADDR_WIDTH),
    .OPTN_MEM_DATA_SIZE (OPTN_MEM_DATA_SIZE),
    .CNT_W              (CNT_W)
  ) u_beat_ctrl (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_base   (req_base),
    .load_nbeats (req_nbeats),
    .advance     (advance),
    .beat_idx    (beat_idx),
    .last        (beat_last),
    .addr        (o_mem_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= PCYN_CCU_RESP_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    advance    = 1'b0;
    o_mem_req  = 1'b0;
    o_mem_we   = 1'b0;
    o_ccu_done = 1'b0;
    case (state_q)
      PCYN_CCU_RESP_IDLE: begin
        if (i_ccu_en) begin
          load    = 1'b1;
          state_d = PCYN_CCU_RESP_BUSY;
        end
      end
      PCYN_CCU_RESP_BUSY: begin
        o_mem_req = 1'b1;
        o_mem_we  = we_q;
        if (i_mem_ack) begin
          advance = 1'b1;
          if (beat_last) state_d = PCYN_CCU_RESP_DONE;
        end
      end
      PCYN_CCU_RESP_DONE: begin
        o_ccu_done = 1'b1;
        state_d    = PCYN_CCU_RESP_IDLE;
      end
      default: state_d = PCYN_CCU_RESP_IDLE;
    endcase
  end

  // One buffer serves both directions: write line on writes, assembled data on reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      line_q <= '0;
    end else if (load) begin
      we_q   <= i_ccu_we;
      line_q <= i_ccu_we ? i_ccu_data : '0;
    end else if (advance && !we_q) begin
      line_q[beat_idx*MEM_W +: MEM_W] <= i_mem_rdata;
    end
  end

  assign o_mem_wdata = line_q[beat_idx*MEM_W +: MEM_W];
  assign o_ccu_data  = line_q;

endmodule

// File: tb/tb_procyon_ccu_mem_responder.sv
// Directed bench for procyon_ccu_mem_responder (default and 8-byte-bus instances).
module tb_procyon_ccu_mem_responder;
  import procyon_lib_pkg::*;

  logic          clk;
  logic          rst;
  logic          en, en_w, we;
  pcyn_ccu_len_t len;
  logic [31:0]   addr;
  logic [255:0]  wdata;

  logic          done, req, mwe, ack;
  logic [255:0]  cdata;
  logic [31:0]   maddr, mwdata, rdata;

  logic          done_w, req_w, mwe_w, ack_w;
  logic [255:0]  cdata_w;
  logic [31:0]   maddr_w;
  logic [63:0]   mwdata_w, rdata_w;

  int checks = 0;
  int fails  = 0;

  procyon_ccu_mem_responder dut (
    .clk(clk), .rst(rst), .i_ccu_en(en), .i_ccu_we(we), .i_ccu_len(len),
    .i_ccu_addr(addr), .i_ccu_data(wdata), .o_ccu_done(done), .o_ccu_data(cdata),
    .o_mem_req(req), .o_mem_we(mwe), .o_mem_addr(maddr), .o_mem_wdata(mwdata),
    .i_mem_ack(ack), .i_mem_rdata(rdata)
  );

  procyon_ccu_mem_responder #(.OPTN_MEM_DATA_SIZE(8)) dut_w (
    .clk(clk), .rst(rst), .i_ccu_en(en_w), .i_ccu_we(we), .i_ccu_len(len),
    .i_ccu_addr(addr), .i_ccu_data(wdata), .o_ccu_done(done_w), .o_ccu_data(cdata_w),
    .o_mem_req(req_w), .o_mem_we(mwe_w), .o_mem_addr(maddr_w), .o_mem_wdata(mwdata_w),
    .i_mem_ack(ack_w), .i_mem_rdata(rdata_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en_w = 1'b0; we = 1'b0; ack = 1'b0; ack_w = 1'b0;
    len = PCYN_CCU_LEN_4B; addr = '0; wdata = '0; rdata = '0; rdata_w = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", req); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (mwe !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", mwe); end
    checks++; if (cdata !== 256'h0) begin fails++; $display("FAIL reset_data got %h exp 0", cdata); end
    checks++; if (req_w !== 1'b0 || done_w !== 1'b0) begin
      fails++; $display("FAIL reset_wide got req=%b done=%b exp 0/0", req_w, done_w);
    end
  endtask

  task automatic test_read32();
    logic [255:0] exp_line;
    exp_line = 256'h08080808_07070707_06060606_05050505_04040404_03030303_02020202_01010101;
    we = 1'b0; len = PCYN_CCU_LEN_32B; addr = 32'h1010; en = 1'b1;
    checks++; if (req !== 1'b0) begin fails++; $display("FAIL rd32_c0_req got %b exp 0", req); end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++; if (req !== 1'b1 || maddr !== 32'h1000 + 32'(4*k) || mwe !== 1'b0) begin
        fails++;
        $display("FAIL rd32_beat%0d got req=%b addr=%h we=%b exp 1/%h/0", k, req, maddr, mwe, 32'h1000 + 32'(4*k));
      end
      ack = 1'b1; rdata = 32'(32'h01010101 * (k + 1));
      tick();
    end
    ack = 1'b0;
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL rd32_done got %b exp 1", done); end
    checks++; if (cdata !== exp_line) begin fails++; $display("FAIL rd32_line got %h exp %h", cdata, exp_line); end
    en = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || req !== 1'b0) begin
      fails++; $display("FAIL rd32_after got done=%b req=%b exp 0/0", done, req);
    end
  endtask

  task automatic test_read32_stall();
    logic [255:0] exp_line;
    exp_line = 256'h80808080_70707070_60606060_50505050_40404040_30303030_20202020_10101010;
    we = 1'b0; len = PCYN_CCU_LEN_32B; addr = 32'h1010; en = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        for (int s = 0; s < 3; s++) begin
          ack = 1'b0;
          checks++; if (req !== 1'b1 || maddr !== 32'h1008) begin
            fails++; $display("FAIL stall_hold%0d got req=%b addr=%h exp 1/1008", s, req, maddr);
          end
          tick();
        end
      end
      checks++; if (maddr !== 32'h1000 + 32'(4*k) || done !== 1'b0) begin
        fails++; $display("FAIL stall_beat%0d got addr=%h done=%b exp %h/0", k, maddr, done, 32'h1000 + 32'(4*k));
      end
      ack = 1'b1; rdata = 32'(32'h10101010 * (k + 1));
      tick();
    end
    ack = 1'b0;
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL stall_done_c12 got %b exp 1", done); end
    checks++; if (cdata !== exp_line) begin fails++; $display("FAIL stall_line got %h exp %h", cdata, exp_line); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_write8();
    we = 1'b1; len = PCYN_CCU_LEN_8B; addr = 32'h204; wdata = 256'h1122334455667788; en = 1'b1;
    tick();
    checks++; if (req !== 1'b1 || mwe !== 1'b1 || maddr !== 32'h200 || mwdata !== 32'h55667788) begin
      fails++; $display("FAIL wr8_beat0 got req=%b we=%b addr=%h wdata=%h exp 1/1/200/55667788", req, mwe, maddr, mwdata);
    end
    ack = 1'b1;
    tick();
    checks++; if (req !== 1'b1 || mwe !== 1'b1 || maddr !== 32'h204 || mwdata !== 32'h11223344) begin
      fails++; $display("FAIL wr8_beat1 got req=%b we=%b addr=%h wdata=%h exp 1/1/204/11223344", req, mwe, maddr, mwdata);
    end
    tick();
    ack = 1'b0;
    checks++; if (done !== 1'b1 || req !== 1'b0) begin
      fails++; $display("FAIL wr8_done got done=%b req=%b exp 1/0", done, req);
    end
    en = 1'b0; we = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || mwe !== 1'b0) begin
      fails++; $display("FAIL wr8_after got done=%b we=%b exp 0/0", done, mwe);
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b0; len = PCYN_CCU_LEN_8B; addr = 32'h300; en = 1'b1;
    tick();
    checks++; if (maddr !== 32'h300) begin fails++; $display("FAIL b2b_a_beat0 got %h exp 300", maddr); end
    ack = 1'b1; rdata = 32'hAAAA0001;
    tick();
    checks++; if (maddr !== 32'h304) begin fails++; $display("FAIL b2b_a_beat1 got %h exp 304", maddr); end
    rdata = 32'hBBBB0002;
    tick();
    ack = 1'b0;
    checks++; if (done !== 1'b1 || cdata !== 256'hBBBB0002_AAAA0001) begin
      fails++; $display("FAIL b2b_a_done got done=%b line=%h exp 1/bbbb0002aaaa0001", done, cdata);
    end
    addr = 32'h40C;
    tick();
    checks++; if (req !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL b2b_idle_gap got req=%b done=%b exp 0/0", req, done);
    end
    tick();
    checks++; if (req !== 1'b1 || maddr !== 32'h408) begin
      fails++; $display("FAIL b2b_b_beat0 got req=%b addr=%h exp 1/408", req, maddr);
    end
    ack = 1'b1; rdata = 32'h0000CCCC;
    tick();
    checks++; if (maddr !== 32'h40C) begin fails++; $display("FAIL b2b_b_beat1 got %h exp 40c", maddr); end
    rdata = 32'h0000DDDD;
    tick();
    ack = 1'b0;
    checks++; if (done !== 1'b1 || cdata !== 256'h0000DDDD_0000CCCC) begin
      fails++; $display("FAIL b2b_b_done got done=%b line=%h exp 1/0000dddd0000cccc", done, cdata);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_short_wide();
    we = 1'b0; len = PCYN_CCU_LEN_4B; addr = 32'h44; en_w = 1'b1;
    tick();
    checks++; if (req_w !== 1'b1 || maddr_w !== 32'h40) begin
      fails++; $display("FAIL wide_beat0 got req=%b addr=%h exp 1/40", req_w, maddr_w);
    end
    ack_w = 1'b1; rdata_w = 64'hCAFEBABE_12345678;
    tick();
    ack_w = 1'b0;
    checks++; if (done_w !== 1'b1 || cdata_w !== 256'hCAFEBABE_12345678) begin
      fails++; $display("FAIL wide_done got done=%b line=%h exp 1/cafebabe12345678", done_w, cdata_w);
    end
    en_w = 1'b0;
    tick();
  endtask

  task automatic test_unknown_len();
    we = 1'b0; len = pcyn_ccu_len_t'(3'd7); addr = 32'h1236; en = 1'b1;
    tick();
    checks++; if (req !== 1'b1 || maddr !== 32'h1234) begin
      fails++; $display("FAIL unk_beat0 got req=%b addr=%h exp 1/1234", req, maddr);
    end
    ack = 1'b1; rdata = 32'h5A5A5A5A;
    tick();
    ack = 1'b0;
    checks++; if (done !== 1'b1 || req !== 1'b0 || cdata !== 256'h5A5A5A5A) begin
      fails++; $display("FAIL unk_done got done=%b req=%b line=%h exp 1/0/5a5a5a5a", done, req, cdata);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [255:0] exp_line;
    exp_line = 256'h08080808_07070707_06060606_05050505_04040404_03030303_02020202_01010101;
    we = 1'b0; len = PCYN_CCU_LEN_64B; addr = 32'h2024; en = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (maddr !== 32'h2020 + 32'(4*k)) begin
        fails++; $display("FAIL rmid_beat%0d got %h exp %h", k, maddr, 32'h2020 + 32'(4*k));
      end
      ack = 1'b1; rdata = 32'hDEADBEEF;
      tick();
    end
    ack = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (req !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL rmid_abort got req=%b done=%b exp 0/0", req, done);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++; if (req !== 1'b1 || maddr !== 32'h2020 + 32'(4*k) || done !== 1'b0) begin
        fails++;
        $display("FAIL rmid_retry%0d got req=%b addr=%h done=%b exp 1/%h/0", k, req, maddr, done, 32'h2020 + 32'(4*k));
      end
      ack = 1'b1; rdata = 32'(32'h01010101 * (k + 1));
      tick();
    end
    ack = 1'b0;
    checks++; if (done !== 1'b1 || cdata !== exp_line) begin
      fails++; $display("FAIL rmid_done got done=%b line=%h exp 1/%h", done, cdata, exp_line);
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read32();
    test_read32_stall();
    test_write8();
    test_back_to_back();
    test_short_wide();
    test_unknown_len();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
